// File: rtl/cpc_ram_pkg.sv
// Shared types and constants for the CPC banked RAM-expansion controller.

package cpc_ram_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_C0 = 3'd0;
   localparam mode_t MODE_C1 = 3'd1;
   localparam mode_t MODE_C2 = 3'd2;
   localparam mode_t MODE_C3 = 3'd3;
   localparam mode_t MODE_C4 = 3'd4;
   localparam mode_t MODE_C5 = 3'd5;
   localparam mode_t MODE_C6 = 3'd6;
   localparam mode_t MODE_C7 = 3'd7;

   typedef enum logic [1:0] {StIdle, StMrd, StMwr, StHold} cyc_state_e;

   localparam logic [2:0] SHADOW_BANK = 3'b111;

endpackage

// File: rtl/cpc_ram_map.sv
// Combinational mode/block decode: yields expansion hit and SRAM high address.

module cpc_ram_map
   import cpc_ram_pkg::*;
#(
   parameter int unsigned BANK_BITS = 3,
   parameter int unsigned PAGE_BITS = 1,
   parameter int unsigned RAMADR_W  = BANK_BITS + PAGE_BITS + 2,
   localparam int unsigned PW       = (PAGE_BITS > 0) ? PAGE_BITS : 1
) (
   input  mode_t                mode,
   input  logic [BANK_BITS-1:0] bank,
   input  logic [PW-1:0]        page,
   input  logic [1:0]           blk,
   input  logic                 shadow,
   input  logic                 is_wr,
   output logic                 hit,
   output logic [RAMADR_W-1:0]  ramadrhi
);

   logic                 hit_exp;
   logic [1:0]           exp_blk;
   logic [BANK_BITS-1:0] vbank;
   logic [PW-1:0]        out_page;
   logic [BANK_BITS-1:0] out_bank;
   logic [1:0]           out_blk;
   logic [PW+BANK_BITS+1:0] full_adr;

   always_comb begin
      hit_exp = 1'b0;
      exp_blk = blk;
      unique case (mode)
         MODE_C0: hit_exp = 1'b0;
         MODE_C1: begin
            hit_exp = (blk == 2'b11);
            exp_blk = 2'b11;
         end
         MODE_C2: hit_exp = 1'b1;
         MODE_C3: begin
            hit_exp = (blk == 2'b11);
            exp_blk = 2'b11;
         end
         MODE_C4, MODE_C5, MODE_C6, MODE_C7: begin
            hit_exp = (blk == 2'b01);
            exp_blk = mode[1:0];
         end
      endcase

      // Page 0 bank 7 is reserved for shadow writes, so user bank 7 folds onto 6
      vbank = bank;
      if (shadow && (page == '0) && (bank == SHADOW_BANK)) vbank = 3'b110;

      hit      = hit_exp;
      out_page = page;
      out_bank = vbank;
      out_blk  = exp_blk;
      if (!hit_exp && shadow && is_wr) begin
         hit      = 1'b1;
         out_page = '0;
         out_bank = SHADOW_BANK;
         out_blk  = blk;
      end

      full_adr = {out_page, out_bank, out_blk};
      ramadrhi = full_adr[RAMADR_W-1:0];
   end

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// Banked RAM-expansion controller: port decode, cycle FSM and SRAM/pad drive.
// Optional M4 write-strobe overdrive enabled by defining WR_OVERDRIVE_EN.

module cpc_ram_bank_ctrl
   import cpc_ram_pkg::*;
#(
   parameter int unsigned BANK_BITS = 3,
   parameter int unsigned PAGE_BITS = 1,
   parameter int unsigned RAMADR_W  = BANK_BITS + PAGE_BITS + 2
) (
   input  logic                           clk,
   input  logic                           reset_b,
   input  logic [15:0]                    adr,
   input  logic [7:0]                     data,
   input  logic                           iorq_b,
   input  logic                           mreq_b,
   input  logic                           rfsh_b,
   input  logic                           m1_b,
   input  logic                           wr_b_in,
   input  logic                           rd_b_in,
   input  logic                           ramrd_b,
   input  logic                           shadow,
   output logic                           ramcs_b,
   output logic                           ramoe_b,
   output logic                           ramwe_b,
   output logic [RAMADR_W-1:0]            ramadrhi,
   output logic                           ramdis,
   output logic                           ramdis_oe,
   output logic                           a15_od,
   output logic                           wr_od,
   output logic [BANK_BITS+PAGE_BITS+2:0] bank_q
);

   localparam int unsigned PW = (PAGE_BITS > 0) ? PAGE_BITS : 1;

   logic rst_meta, rst_s;
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rst_meta <= 1'b0;
         rst_s    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_s    <= rst_meta;
      end
   end

   logic                 unused_adr;
   logic                 io_strobe, io_strobe_q, port_wr;
   logic [PW-1:0]        page_new;
   logic [PW-1:0]        sel_page_q, cyc_page_q, act_page;
   logic [BANK_BITS-1:0] sel_bank_q, cyc_bank_q, act_bank;
   mode_t                sel_mode_q, cyc_mode_q, act_mode;
   logic [1:0]           cyc_blk_q, blk_now, act_blk;
   logic                 cyc_od_q, od_now, act_od;
   logic                 cyc_wr_q, act_wr;
   logic                 mreq_q, idle, start, hit, active;
   logic [RAMADR_W-1:0]  map_adr;
   logic [PW+BANK_BITS+2:0] bank_full;
   cyc_state_e           state_q, state_d;

   assign unused_adr = ^adr;
   assign io_strobe  = ~iorq_b & ~wr_b_in;
   assign port_wr    = io_strobe & ~io_strobe_q & ~adr[15] & (data[7:6] == 2'b11);
   assign page_new   = (PAGE_BITS > 0) ? ~adr[8 +: PW] : '0;

   assign idle   = (state_q == StIdle);
   assign start  = idle & mreq_q & ~mreq_b & rfsh_b;
   // Block 1 in mode 3 is overdriven to &C000, so it decodes as block 3
   assign od_now = (sel_mode_q == MODE_C3) & ~adr[15] & adr[14];
   assign blk_now = {adr[15] | od_now, adr[14]};

   // Outside a cycle the live register drives the map; inside, the copy taken at cycle start
   assign act_page = idle ? sel_page_q : cyc_page_q;
   assign act_bank = idle ? sel_bank_q : cyc_bank_q;
   assign act_mode = idle ? sel_mode_q : cyc_mode_q;
   assign act_blk  = idle ? blk_now : cyc_blk_q;
   assign act_od   = idle ? od_now : cyc_od_q;
   assign act_wr   = idle ? (rd_b_in & m1_b) : cyc_wr_q;

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         io_strobe_q <= 1'b0;
         mreq_q      <= 1'b1;
         sel_page_q  <= '0;
         sel_bank_q  <= '0;
         sel_mode_q  <= MODE_C0;
         cyc_page_q  <= '0;
         cyc_bank_q  <= '0;
         cyc_mode_q  <= MODE_C0;
         cyc_blk_q   <= 2'b00;
         cyc_od_q    <= 1'b0;
         cyc_wr_q    <= 1'b0;
      end else begin
         io_strobe_q <= io_strobe;
         mreq_q      <= mreq_b;
         if (port_wr) begin
            sel_page_q <= page_new;
            sel_bank_q <= data[5:3];
            sel_mode_q <= data[2:0];
         end
         if (start) begin
            cyc_page_q <= sel_page_q;
            cyc_bank_q <= sel_bank_q;
            cyc_mode_q <= sel_mode_q;
            cyc_blk_q  <= blk_now;
            cyc_od_q   <= od_now;
            cyc_wr_q   <= rd_b_in & m1_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:       if (start) state_d = (rd_b_in & m1_b) ? StMwr : StMrd;
         StMrd, StMwr: state_d = mreq_b ? StIdle : StHold;
         StHold:       if (mreq_b) state_d = StIdle;
      endcase
   end

   cpc_ram_map #(
      .BANK_BITS (BANK_BITS),
      .PAGE_BITS (PAGE_BITS),
      .RAMADR_W  (RAMADR_W)
   ) u_map (
      .mode     (act_mode),
      .bank     (act_bank),
      .page     (act_page),
      .blk      (act_blk),
      .shadow   (shadow),
      .is_wr    (act_wr),
      .hit      (hit),
      .ramadrhi (map_adr)
   );

   always_comb begin
      active    = rst_s & ~mreq_b & rfsh_b;
      ramcs_b   = ~(active & hit);
      ramdis    = active & hit & ~act_wr;
      ramdis_oe = ramdis;
      a15_od    = active & act_od;
      ramadrhi  = (rst_s & hit) ? map_adr : '0;
`ifdef WR_OVERDRIVE_EN
      wr_od     = active & hit & ~shadow & (state_q == StMwr);
`else
      wr_od     = 1'b0;
`endif
   end

   assign ramoe_b   = ramrd_b;
   assign ramwe_b   = wr_b_in;
   assign bank_full = {sel_page_q, sel_bank_q, sel_mode_q};
   assign bank_q    = bank_full[BANK_BITS+PAGE_BITS+2:0];

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Scoreboard bench for cpc_ram_bank_ctrl: directed bus cycles, queued expectations.

module tb_cpc_ram_bank_ctrl;

   localparam int S_CS = 0, S_DIS = 1, S_DISOE = 2, S_A15 = 3, S_WROD = 4, S_ADR = 5, S_BANK = 6;
`ifdef WR_OVERDRIVE_EN
   localparam logic [7:0] WR_EXP = 8'd1;
`else
   localparam logic [7:0] WR_EXP = 8'd0;
`endif

   logic clk = 1'b0, reset_b = 1'b0;
   logic [15:0] adr = 16'hFFFF;
   logic [7:0] data = 8'h00;
   logic iorq_b = 1'b1, mreq_b = 1'b1, rfsh_b = 1'b1, m1_b = 1'b1;
   logic wr_b_in = 1'b1, rd_b_in = 1'b1, ramrd_b = 1'b1, shadow = 1'b0;
   logic ramcs_b, ramoe_b, ramwe_b, ramdis, ramdis_oe, a15_od, wr_od;
   logic [5:0] ramadrhi;
   logic [6:0] bank_q;

   cpc_ram_bank_ctrl #(.BANK_BITS(3), .PAGE_BITS(1), .RAMADR_W(6)) dut (
      .clk(clk), .reset_b(reset_b), .adr(adr), .data(data), .iorq_b(iorq_b),
      .mreq_b(mreq_b), .rfsh_b(rfsh_b), .m1_b(m1_b), .wr_b_in(wr_b_in), .rd_b_in(rd_b_in),
      .ramrd_b(ramrd_b), .shadow(shadow), .ramcs_b(ramcs_b), .ramoe_b(ramoe_b),
      .ramwe_b(ramwe_b), .ramadrhi(ramadrhi), .ramdis(ramdis), .ramdis_oe(ramdis_oe),
      .a15_od(a15_od), .wr_od(wr_od), .bank_q(bank_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, failures = 0;
   event sample_ev;

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         S_CS:    return {7'd0, ramcs_b};
         S_DIS:   return {7'd0, ramdis};
         S_DISOE: return {7'd0, ramdis_oe};
         S_A15:   return {7'd0, a15_od};
         S_WROD:  return {7'd0, wr_od};
         S_ADR:   return {2'd0, ramadrhi};
         default: return {1'b0, bank_q};
      endcase
   endfunction

   // Monitor: drains the scoreboard whenever the stimulus marks a sample point
   initial begin
      forever begin
         @(sample_ev);
         while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = sb.pop_front();
            act = observe(e.sel);
            checks++;
            if (act !== e.val) begin
               failures++;
               $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic expect_val(input string n, input int sel, input logic [7:0] v);
      exp_t e;
      e.name = n;
      e.sel  = sel;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic sample();
      -> sample_ev;
      #1;
   endtask

   task automatic out_port(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      adr = a; data = d; iorq_b = 1'b0; wr_b_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      iorq_b = 1'b1; wr_b_in = 1'b1; data = 8'h00;
      @(posedge clk); #1;
   endtask

   task automatic mem_begin(input logic [15:0] a, input logic wr);
      @(posedge clk); #1;
      adr = a; rd_b_in = wr; wr_b_in = ~wr; mreq_b = 1'b0;
      #1;
   endtask

   task automatic next_clk();
      @(posedge clk); #2;
   endtask

   task automatic mem_end();
      @(posedge clk); #1;
      mreq_b = 1'b1; rd_b_in = 1'b1; wr_b_in = 1'b1; iorq_b = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_b = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      expect_val("rst_cs", S_CS, 8'd1);
      expect_val("rst_bank", S_BANK, 8'd0);
      expect_val("rst_disoe", S_DISOE, 8'd0);
      expect_val("rst_a15", S_A15, 8'd0);
      expect_val("rst_wrod", S_WROD, 8'd0);
      sample();
      mem_begin(16'h4000, 1'b0);
      expect_val("m0_rd4000_cs", S_CS, 8'd1);
      sample();
      mem_end();

      // Mode 2, page 0 bank 0: all blocks map straight through
      out_port(16'h7FFF, 8'hC2);
      expect_val("c2_bank", S_BANK, 8'b0000010);
      sample();
      mem_begin(16'h8000, 1'b0);
      expect_val("c2_rd8000_cs", S_CS, 8'd0);
      expect_val("c2_rd8000_adr", S_ADR, 8'b000010);
      expect_val("c2_rd8000_dis", S_DIS, 8'd1);
      expect_val("c2_rd8000_disoe", S_DISOE, 8'd1);
      sample();
      next_clk();
      expect_val("c2_rd8000_cs_mrd", S_CS, 8'd0);
      sample();
      mem_end();

      // Page 1, bank 1, mode 7: block 1 -> expansion block 3
      out_port(16'h7EFF, 8'hCF);
      expect_val("cf_bank", S_BANK, 8'b1001111);
      sample();
      mem_begin(16'h4000, 1'b0);
      expect_val("cf_rd4000_cs", S_CS, 8'd0);
      expect_val("cf_rd4000_adr", S_ADR, 8'b100111);
      sample();
      mem_end();
      mem_begin(16'hC000, 1'b0);
      expect_val("cf_rdc000_cs", S_CS, 8'd1);
      expect_val("cf_rdc000_dis", S_DIS, 8'd0);
      sample();
      mem_end();

      // Mode 3: block 1 overdrives A15 and hits expansion block 3
      out_port(16'h7FFF, 8'hC3);
      mem_begin(16'h4000, 1'b0);
      expect_val("c3_rd4000_a15_start", S_A15, 8'd1);
      expect_val("c3_rd4000_cs", S_CS, 8'd0);
      expect_val("c3_rd4000_adr", S_ADR, 8'b000011);
      sample();
      next_clk();
      expect_val("c3_rd4000_a15_mrd", S_A15, 8'd1);
      expect_val("c3_rd4000_adr_mrd", S_ADR, 8'b000011);
      sample();
      mem_end();
      expect_val("c3_a15_release", S_A15, 8'd0);
      sample();
      mem_begin(16'hC000, 1'b0);
      expect_val("c3_rdc000_cs", S_CS, 8'd0);
      expect_val("c3_rdc000_a15", S_A15, 8'd0);
      sample();
      mem_end();

      // Port write and memory cycle in the same clk: cycle keeps the old (mode 3) map
      @(posedge clk); #1;
      adr = 16'h7FFF; data = 8'hC2; iorq_b = 1'b0; wr_b_in = 1'b0; rd_b_in = 1'b0; mreq_b = 1'b0;
      #1;
      expect_val("same_idle_a15", S_A15, 8'd1);
      expect_val("same_idle_adr", S_ADR, 8'b000011);
      sample();
      next_clk();
      expect_val("same_mrd_adr", S_ADR, 8'b000011);
      expect_val("same_mrd_a15", S_A15, 8'd1);
      expect_val("same_bank_new", S_BANK, 8'b0000010);
      sample();
      mem_end();
      mem_begin(16'h4000, 1'b0);
      expect_val("same_next_adr", S_ADR, 8'b000001);
      expect_val("same_next_a15", S_A15, 8'd0);
      sample();
      mem_end();

      // Shadow mode: missed writes land in page 0 bank 7
      shadow = 1'b1;
      out_port(16'h7FFF, 8'hC0);
      mem_begin(16'h8123, 1'b1);
      expect_val("sh_wr_cs", S_CS, 8'd0);
      expect_val("sh_wr_adr", S_ADR, 8'b011110);
      expect_val("sh_wr_disoe", S_DISOE, 8'd0);
      sample();
      next_clk();
      expect_val("sh_wr_wrod", S_WROD, 8'd0);
      sample();
      mem_end();
      mem_begin(16'h8123, 1'b0);
      expect_val("sh_rd_cs", S_CS, 8'd1);
      sample();
      mem_end();
      out_port(16'h7FFF, 8'hF9);
      mem_begin(16'hC000, 1'b0);
      expect_val("sh_bank7_alias_adr", S_ADR, 8'b011011);
      sample();
      mem_end();
      shadow = 1'b0;

      // Write overdrive window and asynchronous reset mid-write
      out_port(16'h7FFF, 8'hC2);
      mem_begin(16'h0000, 1'b1);
      expect_val("wr_idle_wrod", S_WROD, 8'd0);
      expect_val("wr_idle_cs", S_CS, 8'd0);
      sample();
      next_clk();
      expect_val("wr_mwr_wrod", S_WROD, WR_EXP);
      sample();
      next_clk();
      expect_val("wr_hold_wrod", S_WROD, 8'd0);
      sample();
      mem_end();
      mem_begin(16'h0000, 1'b1);
      next_clk();
      expect_val("wr2_mwr_wrod", S_WROD, WR_EXP);
      sample();
      reset_b = 1'b0;
      #1;
      expect_val("rstmid_wrod", S_WROD, 8'd0);
      expect_val("rstmid_cs", S_CS, 8'd1);
      expect_val("rstmid_bank", S_BANK, 8'd0);
      sample();
      mem_end();
      #1 reset_b = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
